// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - pll_state_e : FSM state encoding (exposed on the debug 'state' port)
//   - STATE_W     : width of the state encoding
//   - DEF_*       : default timing parameters (27 MHz reference clock)
//   - max4        : helper used to size the shared interval counter
package pll_seq_pkg;

    localparam int STATE_W = 3;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms at 27 MHz
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_RESET_HOLD_CYCLES   = 256;
    localparam int DEF_CNT_W               = 8;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST     = 3'd0,
        WAIT_LOCK   = 3'd1,
        LOCK_STABLE = 3'd2,
        HOLD        = 3'd3,
        RUN         = 3'd4
    } pll_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer.
//   clk   : destination clock
//   rst_n : async active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output (2 edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Master PLL supervisor on the reference clock. Pulses pll_reset, waits for
// lock (with timeout), requires lock to be stable for a window, holds the
// system reset a little longer, then releases sys_rst_n. Any lock drop in
// RUN re-resets the PLL and bumps a saturating loss counter.
//   clk        : free-running reference clock (PLL input clock)
//   rst_n      : async active-low reset
//   pll_lock   : raw PLL lock, asynchronous
//   pll_reset  : active-high PLL reset, registered
//   sys_rst_n  : active-low system reset, registered
//   ready      : high only in RUN
//   loss_count : saturating count of lock losses seen in RUN
//   state      : current FSM state (debug)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               ready,
    output logic [CNT_W-1:0]   loss_count,
    output logic [STATE_W-1:0] state
);

    // Counter only ever has to reach (longest interval - 1).
    localparam int MAX_CYC = max4(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);

    pll_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             loss_inc;
    logic             lock_s;
    logic             pll_reset_q, sys_rst_n_q, ready_q;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next state. Each interval ends on the edge where cnt already holds
    // its last value, so a state lasts exactly N edges. Lock is tested
    // before the interval end, which gives lock priority over timeout in
    // WAIT_LOCK and loss priority over completion in LOCK_STABLE/HOLD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        loss_inc = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                     state_d = LOCK_STABLE;
                else if (cnt_q == TIMEOUT_LAST) state_d = PLL_RST;
            end
            LOCK_STABLE: begin
                if (!lock_s)                   state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s)                 state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;  // no interval timed in RUN; avoid free-running wrap
                if (!lock_s) begin
                    state_d  = PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = PLL_RST;  // encodings 5..7 recover
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        loss_d = loss_q;
        if (loss_inc && (loss_q != {CNT_W{1'b1}})) loss_d = loss_q + CNT_W'(1);
    end

    // Outputs are decoded from state_d so they move on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            pll_reset_q <= (state_d == PLL_RST);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_reset  = pll_reset_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign loss_count = loss_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int P_RST  = 3;
    localparam int P_TO   = 50;
    localparam int P_STB  = 8;
    localparam int P_HOLD = 4;
    localparam int P_CW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pll_lock = 1'b0;
    logic              pll_reset, sys_rst_n, ready;
    logic [P_CW-1:0]   loss_count;
    logic [STATE_W-1:0] state;

    int errors = 0;
    int checks = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_STB),
        .RESET_HOLD_CYCLES   (P_HOLD),
        .CNT_W               (P_CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .loss_count (loss_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves us 1 unit past an edge with rst_n released; next edge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [2:0] bad;
        logic       sys_hi;
        int         exp_loss;

        // ---- Power-up ----
        pll_lock = 1'b0;
        rst_n    = 1'b0;
        step(2);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_loss", loss_count, 0);
        check("rst_state", state, PLL_RST);
        rst_n = 1'b1;
        step(2);
        check("pu_pll_reset_e2", pll_reset, 1);
        step(1);
        check("pu_pll_reset_e3", pll_reset, 0);
        check("pu_state_e3", state, WAIT_LOCK);
        step(7);                                  // edge 10
        pll_lock = 1'b1;
        step(2);                                  // edge 12
        check("pu_state_e12", state, WAIT_LOCK);
        step(12);                                 // edge 24
        check("pu_sys_e24", sys_rst_n, 0);
        check("pu_state_e24", state, HOLD);
        step(1);                                  // edge 25
        check("pu_sys_e25", sys_rst_n, 1);
        check("pu_ready_e25", ready, 1);
        check("pu_state_e25", state, RUN);
        check("pu_loss", loss_count, 0);

        // ---- Timeout: lock never arrives ----
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        do_reset();
        sys_hi = 1'b0;
        for (int e = 1; e <= 110; e++) begin
            step(1);
            sys_hi = sys_hi | sys_rst_n;
            if (e == 52)  check("to_pll_reset_e52", pll_reset, 0);
            if (e == 53)  check("to_pll_reset_e53", pll_reset, 1);
            if (e == 55)  check("to_pll_reset_e55", pll_reset, 1);
            if (e == 56)  check("to_pll_reset_e56", pll_reset, 0);
            if (e == 105) check("to_pll_reset_e105", pll_reset, 0);
            if (e == 106) check("to_pll_reset_e106", pll_reset, 1);
            if (e == 109) check("to_pll_reset_e109", pll_reset, 0);
        end
        check("to_sys_never_high", sys_hi, 0);
        check("to_loss", loss_count, 0);

        // ---- Lock on the final WAIT_LOCK cycle: lock beats timeout ----
        do_reset();
        step(50);
        pll_lock = 1'b1;
        step(2);                                  // edge 52
        check("sim_state_e52", state, WAIT_LOCK);
        step(1);                                  // edge 53
        check("sim_state_e53", state, LOCK_STABLE);
        check("sim_pll_reset_e53", pll_reset, 0);
        step(11);                                 // edge 64
        check("sim_sys_e64", sys_rst_n, 0);
        step(1);                                  // edge 65
        check("sim_sys_e65", sys_rst_n, 1);

        // ---- Unstable lock in LOCK_STABLE ----
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        do_reset();
        step(10);
        pll_lock = 1'b1;
        step(6);                                  // edge 16
        pll_lock = 1'b0;
        step(2);                                  // edge 18
        pll_lock = 1'b1;
        check("ul_state_e18", state, LOCK_STABLE);
        step(1);                                  // edge 19
        check("ul_state_e19", state, WAIT_LOCK);
        step(1);                                  // edge 20
        check("ul_state_e20", state, WAIT_LOCK);
        step(12);                                 // edge 32
        check("ul_sys_e32", sys_rst_n, 0);
        step(1);                                  // edge 33
        check("ul_sys_e33", sys_rst_n, 1);
        check("ul_loss", loss_count, 0);

        // ---- Repeated loss in RUN, counter saturates at 3 ----
        for (int k = 1; k <= 4; k++) begin
            exp_loss = (k > 3) ? 3 : k;
            pll_lock = 1'b0;
            step(2);
            check("loss_sys_before", sys_rst_n, 1);
            step(1);
            check("loss_sys", sys_rst_n, 0);
            check("loss_ready", ready, 0);
            check("loss_pll_reset", pll_reset, 1);
            check("loss_count", loss_count, 8'(exp_loss));
            pll_lock = 1'b1;
            step(16);
            check("loss_relock_sys", sys_rst_n, 1);
        end

        // ---- Async reset mid-HOLD and mid-RUN, lock held high ----
        do_reset();
        step(13);
        check("mr_state_hold", state, HOLD);
        #2 rst_n = 1'b0;
        #1;
        check("mr_hold_state", state, PLL_RST);
        check("mr_hold_pll_reset", pll_reset, 1);
        check("mr_hold_sys", sys_rst_n, 0);
        check("mr_hold_ready", ready, 0);
        check("mr_hold_loss", loss_count, 0);
        #1 rst_n = 1'b1;
        step(15);
        check("mr_replay_sys_e15", sys_rst_n, 0);
        step(1);
        check("mr_replay_sys_e16", sys_rst_n, 1);
        check("mr_replay_state", state, RUN);
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_run_sys", sys_rst_n, 0);
        check("mr_run_ready", ready, 0);
        check("mr_run_pll_reset", pll_reset, 1);
        check("mr_run_state", state, PLL_RST);
        #1 rst_n = 1'b1;
        step(16);
        check("mr_replay2_sys", sys_rst_n, 1);

        // ---- Illegal state encoding recovers to PLL_RST ----
        bad = 3'd6;
        force dut.state_q = pll_state_e'(bad);
        #1;
        check("ill_state_forced", state, 6);
        step(1);
        check("ill_pll_reset", pll_reset, 1);
        check("ill_sys", sys_rst_n, 0);
        check("ill_ready", ready, 0);
        check("ill_loss", loss_count, 0);
        release dut.state_q;
        step(1);
        check("ill_state_after", state, PLL_RST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
